// File: rtl/ef_uart_apb_ctrl.sv
// ef_uart_apb_ctrl: autonomous APB master that initialises an EF_UART_APB and
// moves bytes between its FIFOs and a pair of valid/ready byte streams.
module ef_uart_apb_ctrl #(
    parameter logic [15:0] PR_INIT   = 16'd10,
    parameter logic [13:0] CFG_INIT  = 14'b111111_000_0_1000,
    parameter logic [4:0]  CTRL_INIT = 5'b0_0_1_1_1,
    parameter int unsigned POLL_GAP  = 4
) (
    input  logic        PCLK,
    input  logic        PRESET,
    output logic [15:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        init_done,
    output logic [2:0]  err_flags,
    output logic [7:0]  err_cnt
);
    localparam logic [15:0] A_RXDATA = 16'h0000;
    localparam logic [15:0] A_TXDATA = 16'h0004;
    localparam logic [15:0] A_PR     = 16'h0008;
    localparam logic [15:0] A_CTRL   = 16'h000C;
    localparam logic [15:0] A_CFG    = 16'h0010;
    localparam logic [15:0] A_RIS    = 16'h0F08;
    localparam logic [15:0] A_IC     = 16'h0F0C;

    typedef enum logic [3:0] {
        S_RST, S_INIT_PR, S_INIT_CFG, S_INIT_CTRL, S_GAP, S_POLL, S_DECIDE,
        S_ERR_CLR, S_RX_RD, S_RX_IC, S_TX_WR, S_TX_IC
    } state_t;

    state_t      state_q, state_d, gap_entry;
    logic        psel_q, penable_q, pwrite_q, pwrite_d;
    logic [15:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d, ris_q;
    logic        tx_ready_q, rx_valid_q, init_done_q, last_rx_q;
    logic [7:0]  rx_data_q, err_cnt_q, gap_q;
    logic [2:0]  err_flags_q;
    logic        done, err_elig, rx_elig, tx_elig, launch;

    assign done      = psel_q & penable_q & PREADY;
    assign err_elig  = |ris_q[8:6];
    assign rx_elig   = ris_q[3] & ~rx_valid_q;
    assign tx_elig   = ris_q[0] & tx_valid;
    assign gap_entry = (POLL_GAP == 0) ? S_POLL : S_GAP;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:       state_d = S_INIT_PR;
            S_INIT_PR:   if (done) state_d = S_INIT_CFG;
            S_INIT_CFG:  if (done) state_d = S_INIT_CTRL;
            S_INIT_CTRL, S_ERR_CLR, S_RX_IC, S_TX_IC: if (done) state_d = gap_entry;
            S_GAP:       if (gap_q == 8'd0) state_d = S_POLL;
            S_POLL:      if (done) state_d = S_DECIDE;
            // RX and TX both eligible: take whichever did not win last time
            S_DECIDE:    state_d = err_elig ? S_ERR_CLR :
                                   (rx_elig && !(tx_elig && last_rx_q)) ? S_RX_RD :
                                   tx_elig ? S_TX_WR : gap_entry;
            S_RX_RD:     if (done) state_d = S_RX_IC;
            S_TX_WR:     if (done) state_d = S_TX_IC;
            default:     state_d = S_RST;
        endcase
    end

    always_comb begin
        paddr_d  = A_IC;
        pwrite_d = 1'b1;
        pwdata_d = 32'h0;
        case (state_d)
            S_INIT_PR:   begin paddr_d = A_PR;   pwdata_d = {16'b0, PR_INIT}; end
            S_INIT_CFG:  begin paddr_d = A_CFG;  pwdata_d = {18'b0, CFG_INIT}; end
            S_INIT_CTRL: begin paddr_d = A_CTRL; pwdata_d = {27'b0, CTRL_INIT}; end
            S_POLL:      begin paddr_d = A_RIS;  pwrite_d = 1'b0; end
            S_RX_RD:     begin paddr_d = A_RXDATA; pwrite_d = 1'b0; end
            S_ERR_CLR:   pwdata_d = ris_q & 32'h1C0;
            S_RX_IC:     pwdata_d = 32'h8;
            S_TX_WR:     begin paddr_d = A_TXDATA; pwdata_d = {24'b0, tx_data}; end
            S_TX_IC:     pwdata_d = 32'h1;
            default:     ;
        endcase
    end

    assign launch = (state_d != state_q) && !(state_d inside {S_RST, S_GAP, S_DECIDE});

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= S_RST;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 16'h0;
            pwdata_q    <= 32'h0;
            ris_q       <= 32'h0;
            tx_ready_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 8'h0;
            init_done_q <= 1'b0;
            err_flags_q <= 3'b0;
            err_cnt_q   <= 8'h0;
            last_rx_q   <= 1'b0;
            gap_q       <= 8'h0;
        end else begin
            state_q    <= state_d;
            tx_ready_q <= launch && state_d == S_TX_WR;
            if (launch) begin
                psel_q    <= 1'b1;
                penable_q <= 1'b0;
                paddr_q   <= paddr_d;
                pwrite_q  <= pwrite_d;
                pwdata_q  <= pwdata_d;
            end else if (done) begin
                psel_q    <= 1'b0;
                penable_q <= 1'b0;
            end else if (psel_q) begin
                penable_q <= 1'b1;
            end
            if (state_q == S_POLL && done) ris_q <= PRDATA;
            if (state_q == S_INIT_CTRL && done) init_done_q <= 1'b1;
            if (state_q == S_RX_RD && done) begin
                rx_data_q  <= PRDATA[7:0];
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            if (launch && state_d == S_ERR_CLR) begin
                err_flags_q <= err_flags_q | ris_q[8:6];
                err_cnt_q   <= err_cnt_q + {7'b0, err_cnt_q != 8'hFF};
            end
            if (launch && (state_d == S_RX_RD || state_d == S_TX_WR)) last_rx_q <= (state_d == S_RX_RD);
            gap_q <= (state_q == S_GAP) ? gap_q - 8'd1 : 8'(POLL_GAP - 1);
        end
    end

    assign PADDR     = paddr_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign tx_ready  = tx_ready_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign init_done = init_done_q;
    assign err_flags = err_flags_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_ef_uart_apb_ctrl.sv
// tb_ef_uart_apb_ctrl: directed stimulus with a UART slave model; expected APB
// transfers, RX bytes and status values are queued and checked by a monitor.
module tb_ef_uart_apb_ctrl;
    logic        clk = 1'b0;
    logic        PRESET = 1'b1;
    logic        PREADY = 1'b1;
    logic [7:0]  tx_data = 8'h0;
    logic        tx_valid = 1'b0;
    logic        rx_ready = 1'b1;
    logic [31:0] ris_m = 32'h0;
    logic [7:0]  rxd_m = 8'h0;
    logic [15:0] PADDR;
    logic        PSEL, PENABLE, PWRITE, tx_ready, rx_valid, init_done;
    logic [31:0] PWDATA, PRDATA;
    logic [7:0]  rx_data, err_cnt;
    logic [2:0]  err_flags;
    int          cyc = 0;
    int          nvec = 0;
    int          nerr = 0;

    typedef struct { logic wr; logic [15:0] addr; logic [31:0] data; int c; } apb_t;
    typedef struct { int sel; logic [63:0] exp; string name; } chk_t;
    apb_t       exp_apb[$];
    logic [7:0] exp_rx[$];
    chk_t       chk_q[$];

    ef_uart_apb_ctrl dut (
        .PCLK(clk), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .init_done(init_done), .err_flags(err_flags), .err_cnt(err_cnt)
    );

    assign PRDATA = (PADDR == 16'h0F08) ? ris_m : (PADDR == 16'h0000) ? {24'b0, rxd_m} : 32'h0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = PRESET ? 0 : cyc + 1;
    end

    function automatic logic [63:0] probe(input int sel);
        case (sel)
            0: return {63'b0, init_done};
            1: return {61'b0, err_flags};
            2: return {56'b0, err_cnt};
            3: return {62'b0, PSEL, PENABLE};
            4: return {63'b0, rx_valid};
            5: return {63'b0, tx_ready};
            6: return {15'b0, PWRITE, PADDR, PWDATA};
            7: return {42'b0, tx_ready, rx_valid, init_done, rx_data, err_flags, err_cnt};
            8: return 64'(exp_apb.size());
            default: return 64'(exp_rx.size());
        endcase
    endfunction

    // Monitor: every completed non-poll APB transfer, RX handshake and queued
    // status probe is compared on the falling edge.
    initial begin
        apb_t e;
        chk_t k;
        logic [7:0] r;
        forever begin
            @(negedge clk);
            if (PSEL && PENABLE && PREADY && !(!PWRITE && PADDR == 16'h0F08)) begin
                nvec++;
                if (exp_apb.size() == 0) begin
                    nerr++;
                    $display("FAIL apb_unexpected: got wr=%0b addr=%h data=%h, required no transfer", PWRITE, PADDR, PWDATA);
                end else begin
                    e = exp_apb.pop_front();
                    if (PWRITE !== e.wr || PADDR !== e.addr || (e.wr && PWDATA !== e.data) || (e.c >= 0 && cyc != e.c)) begin
                        nerr++;
                        $display("FAIL apb_xfer: got wr=%0b addr=%h data=%h cyc=%0d, required wr=%0b addr=%h data=%h cyc=%0d",
                                 PWRITE, PADDR, PWDATA, cyc, e.wr, e.addr, e.data, e.c);
                    end
                end
            end
            if (rx_valid && rx_ready) begin
                nvec++;
                r = (exp_rx.size() == 0) ? 8'hxx : exp_rx.pop_front();
                if (rx_data !== r) begin
                    nerr++;
                    $display("FAIL rx_byte: got %h, required %h", rx_data, r);
                end
            end
            while (chk_q.size() != 0) begin
                k = chk_q.pop_front();
                nvec++;
                if (probe(k.sel) !== k.exp) begin
                    nerr++;
                    $display("FAIL %s: got %h, required %h", k.name, probe(k.sel), k.exp);
                end
            end
        end
    end

    task automatic xp(input logic wr, input logic [15:0] a, input logic [31:0] d, input int c);
        exp_apb.push_back('{wr, a, d, c});
    endtask

    task automatic chk(input int sel, input logic [63:0] v, input string name);
        chk_q.push_back('{sel, v, name});
    endtask

    // 0: tx_ready, 1: rx_valid, 2: err_cnt nonzero; returns just after the next rising edge
    task automatic wait_for(input int which);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (which == 0 ? tx_ready : which == 1 ? rx_valid : (err_cnt != 8'd0)) break;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_init();
        xp(1'b1, 16'h0008, 32'd10, 2);
        xp(1'b1, 16'h0010, 32'h3F08, 4);
        xp(1'b1, 16'h000C, 32'h7, 6);
    endtask

    task automatic check_init_done();
        do begin @(posedge clk); #1; end while (cyc < 6);
        chk(0, 64'd0, "init_done_c6");
        @(posedge clk);
        #1;
        chk(0, 64'd1, "init_done_c7");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk(3, 64'd0, "rst_psel_penable");
        chk(6, 64'd0, "rst_apb_regs");
        chk(7, 64'd0, "rst_stream_status");
        expect_init();
        PRESET = 1'b0;
        check_init_done();

        // single RX byte
        rxd_m = 8'hA5;
        xp(1'b0, 16'h0000, 32'h0, -1);
        xp(1'b1, 16'h0F0C, 32'h8, -1);
        exp_rx.push_back(8'hA5);
        ris_m = 32'h9;
        wait_for(1);
        ris_m = 32'h0;
        chk(4, 64'd0, "rx_valid_pulse");
        repeat (20) @(posedge clk);
        #1;

        // two TX bytes
        xp(1'b1, 16'h0004, 32'hC3, -1);
        xp(1'b1, 16'h0F0C, 32'h1, -1);
        xp(1'b1, 16'h0004, 32'h91, -1);
        xp(1'b1, 16'h0F0C, 32'h1, -1);
        tx_data = 8'hC3;
        tx_valid = 1'b1;
        ris_m = 32'h1;
        wait_for(0);
        chk(5, 64'd0, "tx_ready_pulse1");
        tx_data = 8'h91;
        wait_for(0);
        chk(5, 64'd0, "tx_ready_pulse2");
        tx_valid = 1'b0;
        ris_m = 32'h0;
        repeat (20) @(posedge clk);
        #1;

        // RX/TX alternation
        rxd_m = 8'h3C;
        for (int i = 0; i < 2; i++) begin
            xp(1'b0, 16'h0000, 32'h0, -1);
            xp(1'b1, 16'h0F0C, 32'h8, -1);
            xp(1'b1, 16'h0004, i == 0 ? 32'h11 : 32'h22, -1);
            xp(1'b1, 16'h0F0C, 32'h1, -1);
            exp_rx.push_back(8'h3C);
        end
        tx_data = 8'h11;
        tx_valid = 1'b1;
        ris_m = 32'h9;
        wait_for(0);
        tx_data = 8'h22;
        wait_for(0);
        tx_valid = 1'b0;
        ris_m = 32'h0;
        repeat (20) @(posedge clk);
        #1;

        // error clear, then RX on the following pass
        rxd_m = 8'h7E;
        xp(1'b1, 16'h0F0C, 32'h1C0, -1);
        xp(1'b0, 16'h0000, 32'h0, -1);
        xp(1'b1, 16'h0F0C, 32'h8, -1);
        exp_rx.push_back(8'h7E);
        ris_m = 32'h1C8;
        wait_for(2);
        ris_m = 32'h8;
        chk(1, 64'd7, "err_flags");
        chk(2, 64'd1, "err_cnt");
        wait_for(1);
        ris_m = 32'h0;
        repeat (20) @(posedge clk);
        #1;

        // PREADY stall on TXDATA, then reset mid-transfer
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        ris_m = 32'h1;
        wait_for(0);
        PREADY = 1'b0;
        tx_valid = 1'b0;
        ris_m = 32'h0;
        repeat (4) @(posedge clk);
        #1;
        chk(3, 64'd3, "stall_access_held");
        expect_init();
        PRESET = 1'b1;
        @(posedge clk);
        #1;
        PRESET = 1'b0;
        PREADY = 1'b1;
        chk(3, 64'd0, "reset_abandons_xfer");
        chk(1, 64'd0, "reset_err_flags");
        chk(2, 64'd0, "reset_err_cnt");
        check_init_done();

        for (int i = 0; i < 300 && (exp_apb.size() != 0 || exp_rx.size() != 0); i++) @(posedge clk);
        #1;
        chk(8, 64'd0, "apb_expect_left");
        chk(9, 64'd0, "rx_expect_left");
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
